// File: rtl/dl11_console.sv
// DL11-style console interface: RCSR/RBUF/XCSR/XBUF iopage registers and an 8N1 UART.
//
// state   | meaning
// S_IDLE  | line idle; tx waits for an XBUF write, rx waits for a falling edge
// S_START | start bit; tx drives 0, rx waits half a bit time to confirm it
// S_DATA  | eight data bits, LSB first, indexed by a 3-bit counter
// S_STOP  | stop bit; tx drives 1, rx samples it and delivers the character
module dl11_console #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [12:0] BASE_ADDR    = 13'o17560
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] iopage_addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        decode,
    input  logic        iopage_rd,
    input  logic        iopage_wr,
    input  logic        iopage_byte_op,
    input  logic        rs232_rx,
    output logic        rs232_tx,
    output logic        rx_int,
    output logic        tx_int
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic       rie, tie, rdy, done, ovr, frm;
    logic [7:0] rbuf;

    logic [1:0]  reg_sel;
    logic [15:0] rd_word;
    logic        wr_ok, rcsr_wr, xcsr_wr, xbuf_wr, rbuf_rd;
    logic        unused_data;

    uart_state_t      tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_idx, tx_idx_n;
    logic [7:0]       tx_data, tx_data_n;
    logic             tx_line, tx_line_n;
    logic             tx_load, tx_done;

    uart_state_t      rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_idx, rx_idx_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_s1, rx_s2, rx_prev;
    logic             rx_fall, rx_deliver;

    assign decode      = (iopage_addr[12:3] == BASE_ADDR[12:3]);
    assign reg_sel     = iopage_addr[2:1];
    assign unused_data = ^data_in[15:8];

    // Odd-address byte writes never reach a register.
    assign wr_ok   = decode && iopage_wr && !(iopage_byte_op && iopage_addr[0]);
    assign rcsr_wr = wr_ok && (reg_sel == 2'd0);
    assign xcsr_wr = wr_ok && (reg_sel == 2'd2);
    assign xbuf_wr = wr_ok && (reg_sel == 2'd3);
    assign rbuf_rd = decode && iopage_rd && (reg_sel == 2'd1);

    assign rx_int   = done & rie;
    assign tx_int   = rdy & tie;
    assign rs232_tx = tx_line;

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            2'd0:    rd_word = {8'b0, done, rie, 6'b0};
            2'd1:    rd_word = {ovr | frm, ovr, frm, 5'b0, rbuf};
            2'd2:    rd_word = {8'b0, rdy, tie, 6'b0};
            default: rd_word = '0;
        endcase
        data_out = '0;
        if (decode && iopage_rd) begin
            if (iopage_byte_op)
                data_out = {8'b0, iopage_addr[0] ? rd_word[15:8] : rd_word[7:0]};
            else
                data_out = rd_word;
        end
    end

    // The line level is registered alongside the state so it changes exactly at bit boundaries.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_data_n  = tx_data;
        tx_line_n  = tx_line;
        tx_load    = 1'b0;
        tx_done    = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_line_n = 1'b1;
                if (xbuf_wr && rdy) begin
                    tx_state_n = S_START;
                    tx_cnt_n   = BIT_LAST;
                    tx_data_n  = data_in[7:0];
                    tx_line_n  = 1'b0;
                    tx_load    = 1'b1;
                end
            end
            S_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = BIT_LAST;
                    tx_idx_n   = 3'd0;
                    tx_line_n  = tx_data[0];
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            S_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = BIT_LAST;
                    if (tx_idx == 3'd7) begin
                        tx_state_n = S_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_idx_n  = tx_idx + 3'd1;
                        tx_line_n = tx_data[tx_idx + 3'd1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            S_STOP: begin
                if (tx_cnt == '0) begin
                    tx_state_n = S_IDLE;
                    tx_done    = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_data  <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_data  <= tx_data_n;
            tx_line  <= tx_line_n;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_deliver = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = HALF_LAST;
                end
            end
            S_START: begin
                if (rx_cnt == '0) begin
                    if (rx_s2) begin
                        rx_state_n = S_IDLE;
                    end else begin
                        rx_state_n = S_DATA;
                        rx_cnt_n   = BIT_LAST;
                        rx_idx_n   = 3'd0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            S_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_cnt_n   = BIT_LAST;
                    if (rx_idx == 3'd7)
                        rx_state_n = S_STOP;
                    else
                        rx_idx_n = rx_idx + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            S_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_n = S_IDLE;
                    rx_deliver = 1'b1;
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= rs232_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
        end
    end

    // A delivery on the same edge as an RBUF read takes priority; the read masks overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            rie  <= 1'b0;
            tie  <= 1'b0;
            rdy  <= 1'b1;
            done <= 1'b0;
            ovr  <= 1'b0;
            frm  <= 1'b0;
            rbuf <= '0;
        end else begin
            if (rcsr_wr)
                rie <= data_in[6];
            if (xcsr_wr)
                tie <= data_in[6];
            if (tx_load)
                rdy <= 1'b0;
            else if (tx_done)
                rdy <= 1'b1;
            if (rx_deliver) begin
                rbuf <= rx_shift;
                frm  <= ~rx_s2;
                ovr  <= done & ~rbuf_rd;
                done <= 1'b1;
            end else if (rbuf_rd) begin
                done <= 1'b0;
                ovr  <= 1'b0;
                frm  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dl11_console.sv
// Bench for dl11_console: register map, TX frame timing and RX delivery checked against a
// character-level model of the console registers.
module tb_dl11_console;

    localparam int          CPB    = 8;
    localparam logic [12:0] A_RCSR = 13'o17560;
    localparam logic [12:0] A_RBUF = 13'o17562;
    localparam logic [12:0] A_XCSR = 13'o17564;
    localparam logic [12:0] A_XBUF = 13'o17566;

    logic        clk, reset;
    logic [12:0] iopage_addr;
    logic [15:0] data_in, data_out;
    logic        decode, iopage_rd, iopage_wr, iopage_byte_op;
    logic        rs232_rx, rs232_tx, rx_int, tx_int;

    int n_vec = 0;
    int n_err = 0;

    // Character-level model of the console register state.
    logic       m_done, m_ovr, m_frm, m_rie, m_tie;
    logic [7:0] m_rbuf;
    int         deliver_lat = 79;

    dl11_console #(.CLKS_PER_BIT(CPB), .BASE_ADDR(A_RCSR)) dut (
        .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
        .data_out(data_out), .decode(decode), .iopage_rd(iopage_rd), .iopage_wr(iopage_wr),
        .iopage_byte_op(iopage_byte_op), .rs232_rx(rs232_rx), .rs232_tx(rs232_tx),
        .rx_int(rx_int), .tx_int(tx_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_rcsr();
        return {8'b0, m_done, m_rie, 6'b0};
    endfunction

    function automatic logic [15:0] exp_rbuf();
        return {m_ovr | m_frm, m_ovr, m_frm, 5'b0, m_rbuf};
    endfunction

    task automatic model_reset();
        m_done = 0; m_ovr = 0; m_frm = 0; m_rie = 0; m_tie = 0; m_rbuf = 8'h00;
    endtask

    task automatic m_deliver(input logic [7:0] ch, input logic stop, input logic simul_rd);
        m_ovr  = m_done && !simul_rd;
        m_frm  = !stop;
        m_rbuf = ch;
        m_done = 1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [12:0] a, input logic [15:0] d, input logic bop);
        iopage_addr = a; data_in = d; iopage_byte_op = bop; iopage_wr = 1;
        @(posedge clk);
        #1;
        iopage_wr = 0; iopage_byte_op = 0;
    endtask

    task automatic bus_read(input logic [12:0] a, input logic bop, output logic [15:0] d);
        iopage_addr = a; iopage_byte_op = bop; iopage_rd = 1;
        #1;
        d = data_out;
        @(posedge clk);
        #1;
        iopage_rd = 0; iopage_byte_op = 0;
        if (a == A_RBUF || a == A_RBUF + 13'd1) begin
            m_done = 0; m_ovr = 0; m_frm = 0;
        end
    endtask

    // Drives one 8N1 frame; optionally strobes an RBUF read in cycle rd_at; reports the
    // first cycle at which rx_int was seen high.
    task automatic send_serial(input logic [7:0] ch, input logic stop, input int rd_at,
                               output int first_int);
        logic [9:0] fr;
        fr = {stop, ch, 1'b0};
        first_int = -1;
        for (int c = 0; c < 10 * CPB; c++) begin
            if (first_int < 0 && rx_int === 1'b1) first_int = c;
            rs232_rx = fr[c / CPB];
            if (c == rd_at) begin
                iopage_addr = A_RBUF; iopage_rd = 1;
            end else begin
                iopage_rd = 0;
            end
            @(posedge clk);
            #1;
        end
        if (first_int < 0 && rx_int === 1'b1) first_int = 10 * CPB;
        iopage_rd = 0;
        rs232_rx  = 1;
        tick(2);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1; rs232_rx = 1; iopage_rd = 0; iopage_wr = 0; iopage_byte_op = 0;
        iopage_addr = '0; data_in = '0;
        tick(3);
        reset = 0;
        model_reset();
        tick(1);
        n_vec++; if (rs232_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b want 1", rs232_tx); end
        n_vec++; if (rx_int !== 1'b0) begin n_err++; $display("FAIL reset_rx_int got %b want 0", rx_int); end
        n_vec++; if (tx_int !== 1'b0) begin n_err++; $display("FAIL reset_tx_int got %b want 0", tx_int); end
        bus_read(A_XCSR, 0, v);
        n_vec++; if (v !== 16'o000200) begin n_err++; $display("FAIL reset_xcsr got %o want 000200", v); end
        bus_read(A_RCSR, 0, v);
        n_vec++; if (v !== 16'o000000) begin n_err++; $display("FAIL reset_rcsr got %o want 0", v); end
        bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== 16'o000000) begin n_err++; $display("FAIL reset_rbuf got %o want 0", v); end
        bus_read(A_XBUF, 0, v);
        n_vec++; if (v !== 16'o000000) begin n_err++; $display("FAIL xbuf_read got %o want 0", v); end
        iopage_addr = A_RCSR; #1;
        n_vec++; if (decode !== 1'b1) begin n_err++; $display("FAIL decode_low got %b want 1", decode); end
        iopage_addr = A_XBUF + 13'd1; #1;
        n_vec++; if (decode !== 1'b1) begin n_err++; $display("FAIL decode_high got %b want 1", decode); end
        iopage_addr = A_RCSR - 13'd1; #1;
        n_vec++; if (decode !== 1'b0) begin n_err++; $display("FAIL decode_below got %b want 0", decode); end
        iopage_addr = A_XBUF + 13'd2; #1;
        n_vec++; if (decode !== 1'b0) begin n_err++; $display("FAIL decode_above got %b want 0", decode); end
        iopage_addr = A_XCSR; #1;
        n_vec++; if (data_out !== 16'h0000) begin n_err++; $display("FAIL idle_data_out got %o want 0", data_out); end
    endtask

    task automatic test_bus();
        logic [15:0] v;
        bus_write(A_XCSR + 13'd1, 16'hFFFF, 1);
        bus_read(A_XCSR, 0, v);
        n_vec++; if (v !== {8'b0, 1'b1, m_tie, 6'b0}) begin n_err++; $display("FAIL odd_byte_wr got %o want %o", v, {8'b0, 1'b1, m_tie, 6'b0}); end
        bus_write(A_XCSR, 16'hFF40, 1); m_tie = 1;
        bus_read(A_XCSR, 0, v);
        n_vec++; if (v !== 16'o000300) begin n_err++; $display("FAIL even_byte_wr got %o want 000300", v); end
        n_vec++; if (tx_int !== 1'b1) begin n_err++; $display("FAIL tie_tx_int got %b want 1", tx_int); end
        bus_read(A_XCSR + 13'd1, 1, v);
        n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL byte_rd_hi got %o want 0", v); end
        bus_read(A_XCSR, 1, v);
        n_vec++; if (v !== 16'o000300) begin n_err++; $display("FAIL byte_rd_lo got %o want 000300", v); end
        bus_write(A_XCSR, 16'h0000, 0); m_tie = 0;
        n_vec++; if (tx_int !== 1'b0) begin n_err++; $display("FAIL tie_clear got %b want 0", tx_int); end
        bus_write(A_RBUF, 16'hFFFF, 0);
        bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== exp_rbuf()) begin n_err++; $display("FAIL rbuf_wr_ignored got %o want %o", v, exp_rbuf()); end
        bus_write(A_RCSR, 16'o177777, 0); m_rie = 1;
        bus_read(A_RCSR, 0, v);
        n_vec++; if (v !== exp_rcsr()) begin n_err++; $display("FAIL rcsr_rie got %o want %o", v, exp_rcsr()); end
        bus_write(A_RCSR, 16'o000000, 0); m_rie = 0;
        bus_read(A_RCSR, 0, v);
        n_vec++; if (v !== exp_rcsr()) begin n_err++; $display("FAIL rcsr_clear got %o want %o", v, exp_rcsr()); end
    endtask

    // Cycle-by-cycle frame check; an optional second XBUF write lands in cycle mid_at.
    task automatic test_tx(input string name, input logic [7:0] ch, input int mid_at);
        logic [9:0]  fr;
        logic        exp_line, exp_int;
        logic [15:0] exp_x;
        fr = {1'b1, ch, 1'b0};
        bus_write(A_XBUF, {8'hA5, ch}, 0);
        for (int c = 0; c <= 10 * CPB; c++) begin
            if (c == mid_at) begin
                iopage_addr = A_XBUF; data_in = {8'h00, ~ch}; iopage_wr = 1; iopage_rd = 0;
            end else begin
                iopage_wr = 0; iopage_addr = A_XCSR; iopage_rd = 1;
            end
            #1;
            exp_line = (c < 10 * CPB) ? fr[c / CPB] : 1'b1;
            exp_int  = (c >= 10 * CPB) && m_tie;
            n_vec++; if (rs232_tx !== exp_line) begin n_err++; $display("FAIL %s_line c=%0d got %b want %b", name, c, rs232_tx, exp_line); end
            n_vec++; if (tx_int !== exp_int) begin n_err++; $display("FAIL %s_tx_int c=%0d got %b want %b", name, c, tx_int, exp_int); end
            if (c != mid_at) begin
                exp_x = {8'b0, (c >= 10 * CPB), m_tie, 6'b0};
                n_vec++; if (data_out !== exp_x) begin n_err++; $display("FAIL %s_xcsr c=%0d got %o want %o", name, c, data_out, exp_x); end
            end
            @(posedge clk);
            #1;
        end
        iopage_wr = 0; iopage_rd = 0;
    endtask

    task automatic test_tx_all();
        test_tx("tx_101", 8'o101, -1);
        bus_write(A_XCSR, 16'o000100, 0); m_tie = 1;
        n_vec++; if (tx_int !== 1'b1) begin n_err++; $display("FAIL tie_set got %b want 1", tx_int); end
        test_tx("tx_tie", 8'($urandom_range(0, 255)), 3 * CPB + 2);
        for (int i = 0; i < 3; i++)
            test_tx("tx_rand", 8'($urandom_range(0, 255)), (i == 1) ? 9 * CPB + 7 : -1);
    endtask

    task automatic test_tx_reset();
        logic [15:0] v;
        bus_write(A_XBUF, 16'h0000, 0);
        tick(2 * CPB + 4);
        n_vec++; if (rs232_tx !== 1'b0) begin n_err++; $display("FAIL txrst_pre got %b want 0", rs232_tx); end
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        n_vec++; if (rs232_tx !== 1'b1) begin n_err++; $display("FAIL txrst_line got %b want 1", rs232_tx); end
        bus_read(A_XCSR, 0, v);
        n_vec++; if (v !== 16'o000200) begin n_err++; $display("FAIL txrst_xcsr got %o want 000200", v); end
        test_tx("tx_after_rst", 8'($urandom_range(0, 255)), -1);
    endtask

    task automatic test_rx_basic();
        logic [15:0] v, e;
        int          lat;
        bus_write(A_RCSR, 16'o000100, 0); m_rie = 1;
        send_serial(8'h5A, 1, -1, lat);
        m_deliver(8'h5A, 1, 0);
        deliver_lat = lat;
        n_vec++; if (lat < 9 * CPB + CPB / 2 || lat > 10 * CPB) begin n_err++; $display("FAIL rx_latency got %0d want %0d..%0d", lat, 9 * CPB + CPB / 2, 10 * CPB); end
        n_vec++; if (rx_int !== 1'b1) begin n_err++; $display("FAIL rx_int_set got %b want 1", rx_int); end
        e = exp_rcsr(); bus_read(A_RCSR, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL rx_rcsr got %o want %o", v, e); end
        e = exp_rbuf(); bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== e || v !== 16'o000132) begin n_err++; $display("FAIL rx_rbuf got %o want %o", v, e); end
        n_vec++; if (rx_int !== 1'b0) begin n_err++; $display("FAIL rx_int_clr got %b want 0", rx_int); end
        bus_read(A_RBUF + 13'd1, 1, v);
        n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL rbuf_hi_byte got %o want 0", v); end
        e = exp_rcsr(); bus_read(A_RCSR, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL rx_done_clr got %o want %o", v, e); end
    endtask

    task automatic test_rx_errors();
        logic [15:0] v, e;
        logic [7:0]  ch;
        logic        stop, do_read;
        int          lat;
        send_serial(8'h31, 1, -1, lat); m_deliver(8'h31, 1, 0);
        send_serial(8'h32, 1, -1, lat); m_deliver(8'h32, 1, 0);
        e = exp_rbuf(); bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== e || v !== 16'o140062) begin n_err++; $display("FAIL rx_overrun got %o want %o", v, e); end
        ch = 8'($urandom_range(0, 255));
        send_serial(ch, 0, -1, lat); m_deliver(ch, 0, 0);
        e = exp_rbuf(); bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== e || v[15:13] !== 3'b101) begin n_err++; $display("FAIL rx_framing got %o want %o", v, e); end
        for (int i = 0; i < 6; i++) begin
            ch = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            do_read = 1'($urandom_range(0, 1));
            send_serial(ch, stop, -1, lat); m_deliver(ch, stop, 0);
            e = exp_rcsr(); bus_read(A_RCSR, 0, v);
            n_vec++; if (v !== e) begin n_err++; $display("FAIL rx_rand_rcsr i=%0d got %o want %o", i, v, e); end
            if (do_read) begin
                e = exp_rbuf(); bus_read(A_RBUF, 0, v);
                n_vec++; if (v !== e) begin n_err++; $display("FAIL rx_rand_rbuf i=%0d got %o want %o", i, v, e); end
            end
        end
        e = exp_rbuf(); bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL rx_rand_last got %o want %o", v, e); end
    endtask

    task automatic test_rx_glitch_break();
        logic [15:0] v, e;
        logic [7:0]  ch;
        int          lat;
        rs232_rx = 0; tick(2); rs232_rx = 1; tick(3 * CPB);
        e = exp_rcsr(); bus_read(A_RCSR, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL rx_glitch got %o want %o", v, e); end
        ch = 8'($urandom_range(0, 255));
        send_serial(ch, 1, -1, lat); m_deliver(ch, 1, 0);
        e = exp_rbuf(); bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL rx_post_glitch got %o want %o", v, e); end
        rs232_rx = 0; tick(12 * CPB);
        m_deliver(8'h00, 0, 0);
        e = exp_rcsr(); bus_read(A_RCSR, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL break_done got %o want %o", v, e); end
        e = exp_rbuf(); bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== e || v !== 16'o120000) begin n_err++; $display("FAIL break_rbuf got %o want %o", v, e); end
        tick(20 * CPB);
        e = exp_rcsr(); bus_read(A_RCSR, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL break_once got %o want %o", v, e); end
        rs232_rx = 1; tick(2 * CPB);
        ch = 8'($urandom_range(0, 255));
        send_serial(ch, 1, -1, lat); m_deliver(ch, 1, 0);
        e = exp_rbuf(); bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL rx_post_break got %o want %o", v, e); end
    endtask

    task automatic test_rx_simultaneous();
        logic [15:0] v, e;
        logic [7:0]  ch;
        int          lat;
        ch = 8'($urandom_range(0, 255));
        send_serial(ch, 1, -1, lat); m_deliver(ch, 1, 0);
        ch = 8'($urandom_range(0, 255));
        send_serial(ch, 1, deliver_lat - 1, lat); m_deliver(ch, 1, 1);
        e = exp_rcsr(); bus_read(A_RCSR, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL simul_rcsr got %o want %o", v, e); end
        e = exp_rbuf(); bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL simul_rbuf got %o want %o", v, e); end
    endtask

    task automatic test_rx_reset();
        logic [15:0] v, e;
        logic [9:0]  fr;
        logic [7:0]  ch;
        int          lat;
        ch = 8'($urandom_range(0, 255));
        send_serial(ch, 1, -1, lat); m_deliver(ch, 1, 0);
        n_vec++; if (rx_int !== m_rie) begin n_err++; $display("FAIL rxrst_pre got %b want %b", rx_int, m_rie); end
        fr = {1'b1, 8'h00, 1'b0};
        for (int c = 0; c < 4 * CPB; c++) begin
            rs232_rx = fr[c / CPB];
            @(posedge clk);
            #1;
        end
        rs232_rx = 1; reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        n_vec++; if (rx_int !== 1'b0) begin n_err++; $display("FAIL rxrst_int got %b want 0", rx_int); end
        tick(2);
        e = exp_rcsr(); bus_read(A_RCSR, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL rxrst_rcsr got %o want %o", v, e); end
        e = exp_rbuf(); bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL rxrst_rbuf got %o want %o", v, e); end
        ch = 8'($urandom_range(0, 255));
        send_serial(ch, 1, -1, lat); m_deliver(ch, 1, 0);
        e = exp_rbuf(); bus_read(A_RBUF, 0, v);
        n_vec++; if (v !== e) begin n_err++; $display("FAIL rxrst_next got %o want %o", v, e); end
    endtask

    initial begin
        test_reset();
        test_bus();
        test_tx_all();
        test_tx_reset();
        test_rx_basic();
        test_rx_errors();
        test_rx_glitch_break();
        test_rx_simultaneous();
        test_rx_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
